fifo_rd_stream: RTL and testbench



---
 rtl/fifo_rd_stream_pkg.sv | 25 ++
 rtl/fifo_rd_lat_pipe.sv | 50 +++++
 rtl/fifo_rd_stream.sv | 132 +++++++++++++
 tb/tb_fifo_rd_stream.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_rd_stream_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_rd_stream_pkg
// Description : Shared constants and helpers for the FIFO read-side drain
//               stage and its read-latency tracking pipe.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_rd_stream_pkg;

  // Legal range of the external memory read latency, in rclk cycles.
  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 3;

  // Width shared by occupancy, in-flight and discard bookkeeping. It holds the
  // largest buffer depth (RD_LAT_MAX + 2 = 5) without wrapping.
  localparam int OCC_W = 3;

  // Buffer depth: one entry per in-flight read plus two, so one word per
  // clock is sustained while the head waits one cycle to be popped.
  function automatic int buf_depth(input int rd_lat);
    return rd_lat + 2;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_rd_lat_pipe.sv
`default_nettype none
// ============================================================================
// Module      : fifo_rd_lat_pipe
// Description : RD_LAT-deep valid shift line that follows accepted reads to
//               the cycle their data returns, with a popcount of reads that
//               are still in flight.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_rd_lat_pipe #(
  parameter int RD_LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_acc,
  output logic       o_ret,
  output logic [1:0] o_cnt
);

  logic [RD_LAT-1:0] r_line;
  logic [1:0]        w_cnt;

  generate
    if (RD_LAT == 1) begin : g_single
      // Single stage: the accepted read returns on the next cycle.
      always_ff @(posedge clk) begin
        if (rst) r_line <= '0;
        else     r_line <= i_acc;
      end
    end else begin : g_multi
      // Shift the accept flag one stage per cycle toward the return point.
      always_ff @(posedge clk) begin
        if (rst) r_line <= '0;
        else     r_line <= {r_line[RD_LAT-2:0], i_acc};
      end
    end
  endgenerate

  // Count every stage still holding an accepted read.
  always_comb begin
    w_cnt = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      w_cnt = w_cnt + {1'b0, r_line[i]};
    end
  end

  assign o_ret = r_line[RD_LAT-1];
  assign o_cnt = w_cnt;

endmodule
`default_nettype wire

// File: rtl/fifo_rd_stream.sv
`default_nettype none
// ============================================================================
// Module      : fifo_rd_stream
// Description : Read-side drain stage of the async FIFO. Issues active-low
//               read requests while space is guaranteed, tracks the memory
//               read latency, buffers returned words and streams them out on
//               a valid/ready interface. clr flushes the buffer and drops the
//               returns that were already in flight.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_rd_stream
  import fifo_rd_stream_pkg::*;
#(
  parameter int DSIZE  = 8,
  parameter int RD_LAT = 1,
  parameter int CNT_W  = 16
) (
  input  logic             rclk,
  input  logic             rrst,
  input  logic             clr,
  input  logic             rempty,
  output logic             rd_req_n,
  input  logic [DSIZE-1:0] rdata_mem,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [DSIZE-1:0] m_data,
  output logic [1:0]       inflight,
  output logic [CNT_W-1:0] word_cnt
);

  localparam int BUF_DEPTH = buf_depth(RD_LAT);
  localparam int IDX_W     = $clog2(BUF_DEPTH);

  generate
    if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_rd_lat
      $error("fifo_rd_stream: RD_LAT must be within 1..3");
    end
  endgenerate

  logic [DSIZE-1:0] r_mem [BUF_DEPTH];
  logic [IDX_W-1:0] r_rd_ptr;
  logic [IDX_W-1:0] r_wr_ptr;
  logic [OCC_W-1:0] r_occ;
  logic [OCC_W-1:0] r_disc;
  logic [CNT_W-1:0] r_word_cnt;

  logic             w_acc;
  logic             w_ret;
  logic [1:0]       w_inflight;
  logic [OCC_W-1:0] w_sum;
  logic             w_room;
  logic             w_push;
  logic             w_pop;

  function automatic logic [IDX_W-1:0] ptr_next(input logic [IDX_W-1:0] p);
    return (p == IDX_W'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  fifo_rd_lat_pipe #(
    .RD_LAT (RD_LAT)
  ) u_lat_pipe (
    .clk   (rclk),
    .rst   (rrst),
    .i_acc (w_acc),
    .o_ret (w_ret),
    .o_cnt (w_inflight)
  );

  // Request only when every word already owed (buffered, in flight, or still
  // to be discarded) plus this one fits in the buffer. Reset also holds it off.
  always_comb begin
    w_sum    = r_occ + {1'b0, w_inflight} + r_disc;
    w_room   = (w_sum < OCC_W'(BUF_DEPTH));
    rd_req_n = ~(~rempty & ~clr & ~rrst & w_room);
    w_acc    = ~rd_req_n & ~rempty;
    w_push   = w_ret & (r_disc == '0) & ~clr;
    w_pop    = (r_occ != '0) & m_ready;
  end

  // Output buffer: register FIFO; a pushed word is presented the next cycle.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_occ    <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (clr) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_occ    <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= rdata_mem;
        r_wr_ptr        <= ptr_next(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= ptr_next(r_rd_ptr);
      end
      r_occ <= r_occ + OCC_W'(w_push) - OCC_W'(w_pop);
    end
  end

  // Discard count: on clr, every read still in flight except one returning
  // this very cycle (dropped by the flush itself) must be thrown away later.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      r_disc <= '0;
    end else if (clr) begin
      r_disc <= OCC_W'(w_inflight) - OCC_W'(w_ret);
    end else if (w_ret && (r_disc != '0)) begin
      r_disc <= r_disc - 1'b1;
    end
  end

  // Delivered-word counter, wraps naturally at 2^CNT_W.
  always_ff @(posedge rclk) begin
    if (rrst || clr) begin
      r_word_cnt <= '0;
    end else if (w_pop) begin
      r_word_cnt <= r_word_cnt + 1'b1;
    end
  end

  assign m_valid  = (r_occ != '0);
  assign m_data   = r_mem[r_rd_ptr];
  assign inflight = w_inflight;
  assign word_cnt = r_word_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_rd_stream
// Description : Self-checking bench for fifo_rd_stream. Two instances:
//               dut0 (RD_LAT=1, CNT_W=4) and dut1 (RD_LAT=2, CNT_W=16), each
//               fed by a small FIFO-memory model and checked by a scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_rd_stream;

  logic       rclk;
  logic       rrst;

  // dut0 side
  logic       clr0, rempty0, rd_req_n0, m_valid0, m_ready0;
  logic [7:0] rdata_mem0, m_data0;
  logic [1:0] inflight0;
  logic [3:0] word_cnt0;

  // dut1 side
  logic        clr1, rempty1, rd_req_n1, m_valid1, m_ready1;
  logic [7:0]  rdata_mem1, m_data1;
  logic [1:0]  inflight1;
  logic [15:0] word_cnt1;

  int checks = 0;
  int errors = 0;

  // FIFO memory models
  logic [7:0] src0 [64];
  logic [7:0] src1 [64];
  int         wr0 = 0, rd0 = 0, acc_cnt0 = 0;
  int         wr1 = 0, rd1 = 0, acc_cnt1 = 0;
  logic [7:0] dly0  = 8'hEE;
  logic [7:0] dly1a = 8'hEE;
  logic [7:0] dly1b = 8'hEE;

  logic [7:0] exp_q0 [$];
  logic [7:0] exp_q1 [$];

  fifo_rd_stream #(.DSIZE(8), .RD_LAT(1), .CNT_W(4)) u_dut0 (
    .rclk      (rclk),
    .rrst      (rrst),
    .clr       (clr0),
    .rempty    (rempty0),
    .rd_req_n  (rd_req_n0),
    .rdata_mem (rdata_mem0),
    .m_valid   (m_valid0),
    .m_ready   (m_ready0),
    .m_data    (m_data0),
    .inflight  (inflight0),
    .word_cnt  (word_cnt0)
  );

  fifo_rd_stream #(.DSIZE(8), .RD_LAT(2), .CNT_W(16)) u_dut1 (
    .rclk      (rclk),
    .rrst      (rrst),
    .clr       (clr1),
    .rempty    (rempty1),
    .rd_req_n  (rd_req_n1),
    .rdata_mem (rdata_mem1),
    .m_valid   (m_valid1),
    .m_ready   (m_ready1),
    .m_data    (m_data1),
    .inflight  (inflight1),
    .word_cnt  (word_cnt1)
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  assign rempty0    = (rd0 == wr0);
  assign rempty1    = (rd1 == wr1);
  assign rdata_mem0 = dly0;
  assign rdata_mem1 = dly1b;

  // Memory model: an accepted read fetches the next word, which appears on
  // rdata_mem RD_LAT cycles later. The FIFO's own clr empties the pointers.
  always @(posedge rclk) begin
    if (!rd_req_n0 && !rempty0) begin
      dly0     <= src0[rd0 & 63];
      rd0      <= rd0 + 1;
      acc_cnt0 <= acc_cnt0 + 1;
    end else begin
      dly0 <= 8'hEE;
    end
    dly1b <= dly1a;
    if (clr1) begin
      rd1   <= wr1;
      dly1a <= 8'hEE;
    end else if (!rd_req_n1 && !rempty1) begin
      dly1a    <= src1[rd1 & 63];
      rd1      <= rd1 + 1;
      acc_cnt1 <= acc_cnt1 + 1;
    end else begin
      dly1a <= 8'hEE;
    end
  end

  // Scoreboard / protocol monitor, sampled mid-cycle before the next edge.
  logic [7:0] e0, e1;
  logic       hold0 = 1'b0, hold1 = 1'b0;
  logic [7:0] held0, held1;
  always @(negedge rclk) begin
    #3;
    if (!rrst) begin
      checks++;
      assert (u_dut0.r_occ <= 3'd3 && u_dut1.r_occ <= 3'd4) else begin
        errors++;
        $error("FAIL occ_bound observed=%0d/%0d expected<=3/4", u_dut0.r_occ, u_dut1.r_occ);
      end
      if (hold0) begin
        checks++;
        assert (m_valid0 === 1'b1 && m_data0 === held0) else begin
          errors++;
          $error("FAIL dut0_stable observed=%0b/%0h expected=1/%0h", m_valid0, m_data0, held0);
        end
      end
      if (hold1 && !clr1) begin
        checks++;
        assert (m_valid1 === 1'b1 && m_data1 === held1) else begin
          errors++;
          $error("FAIL dut1_stable observed=%0b/%0h expected=1/%0h", m_valid1, m_data1, held1);
        end
      end
      if (m_valid0 && m_ready0) begin
        checks++;
        if (exp_q0.size() == 0) begin
          errors++;
          $error("FAIL dut0_extra_word observed=%0h expected=none", m_data0);
        end else begin
          e0 = exp_q0.pop_front();
          assert (m_data0 === e0) else begin
            errors++;
            $error("FAIL dut0_data observed=%0h expected=%0h", m_data0, e0);
          end
        end
      end
      if (m_valid1 && m_ready1 && !clr1) begin
        checks++;
        if (exp_q1.size() == 0) begin
          errors++;
          $error("FAIL dut1_extra_word observed=%0h expected=none", m_data1);
        end else begin
          e1 = exp_q1.pop_front();
          assert (m_data1 === e1) else begin
            errors++;
            $error("FAIL dut1_data observed=%0h expected=%0h", m_data1, e1);
          end
        end
      end
      hold0 = m_valid0 & ~m_ready0;
      hold1 = m_valid1 & ~m_ready1;
      held0 = m_data0;
      held1 = m_data1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge rclk);
  endtask

  task automatic push0(input logic [7:0] d);
    src0[wr0 & 63] = d;
    wr0 = wr0 + 1;
    exp_q0.push_back(d);
  endtask

  task automatic push1(input logic [7:0] d);
    src1[wr1 & 63] = d;
    wr1 = wr1 + 1;
    exp_q1.push_back(d);
  endtask

  initial begin
    int a0;
    rrst = 1'b1; clr0 = 1'b0; clr1 = 1'b0;
    m_ready0 = 1'b1; m_ready1 = 1'b0;
    for (int i = 0; i < 8; i++) push0(8'h10 + 8'(i));

    // Reset held two cycles with data waiting.
    tick(2);
    chk("rst_req_n0", rd_req_n0, 1);
    chk("rst_valid0", m_valid0, 0);
    chk("rst_cnt0", word_cnt0, 0);
    chk("rst_data0", m_data0, 0);
    chk("rst_inflight0", inflight0, 0);
    chk("rst_valid1", m_valid1, 0);
    chk("rst_cnt1", word_cnt1, 0);
    chk("rst_acc0", acc_cnt0, 0);
    rrst = 1'b0;
    #1;
    chk("post_rst_req0", rd_req_n0, 0);

    // Streaming at RD_LAT=1: valid two cycles after first accept, 8 in a row.
    tick(1);
    chk("first_acc0", acc_cnt0, 1);
    chk("ret_cycle_valid0", m_valid0, 0);
    for (int i = 0; i < 8; i++) begin
      tick(1);
      chk("stream_valid0", m_valid0, 1);
    end
    tick(1);
    chk("stream_end_valid0", m_valid0, 0);
    chk("stream_cnt0", word_cnt0, 8);
    chk("stream_drained0", exp_q0.size(), 0);

    // FIFO runs empty after 3 words.
    a0 = acc_cnt0;
    for (int i = 0; i < 3; i++) push0(8'h30 + 8'(i));
    tick(1);
    for (int i = 0; i < 10 && !rempty0; i++) tick(1);
    chk("empty_rempty0", rempty0, 1);
    chk("empty_req_n0", rd_req_n0, 1);
    chk("empty_acc0", acc_cnt0 - a0, 3);
    tick(6);
    chk("empty_drained0", exp_q0.size(), 0);
    chk("empty_cnt0", word_cnt0, 11);

    // Counter wrap at CNT_W=4: 17 words total.
    for (int i = 0; i < 6; i++) push0(8'h60 + 8'(i));
    tick(12);
    chk("wrap_cnt0", word_cnt0, 1);
    chk("wrap_drained0", exp_q0.size(), 0);

    // Backpressure at RD_LAT=2: exactly BUF_DEPTH=4 accepts.
    for (int i = 0; i < 6; i++) push1(8'h40 + 8'(i));
    tick(10);
    chk("bp_acc1", acc_cnt1, 4);
    chk("bp_req_n1", rd_req_n1, 1);
    chk("bp_occ1", u_dut1.r_occ, 4);
    chk("bp_inflight1", inflight1, 0);
    chk("bp_valid1", m_valid1, 1);
    chk("bp_head1", m_data1, 8'h40);
    m_ready1 = 1'b1;
    tick(1);
    m_ready1 = 1'b0;
    chk("bp_resume_req1", rd_req_n1, 0);
    tick(1);
    chk("bp_one_acc1", acc_cnt1, 5);
    chk("bp_req_n_again1", rd_req_n1, 1);
    tick(4);
    chk("bp_occ_again1", u_dut1.r_occ, 4);
    chk("bp_acc_hold1", acc_cnt1, 5);
    chk("bp_head_next1", m_data1, 8'h41);

    // Flush with two reads in flight.
    m_ready1 = 1'b1;
    for (int i = 0; i < 16; i++) push1(8'h50 + 8'(i));
    tick(10);
    chk("pre_clr_inflight1", inflight1, 2);
    clr1 = 1'b1;
    exp_q1.delete();
    #1;
    chk("clr_req_n1", rd_req_n1, 1);
    tick(1);
    clr1 = 1'b0;
    chk("clr_valid1", m_valid1, 0);
    chk("clr_cnt1", word_cnt1, 0);
    chk("clr_disc1", u_dut1.r_disc, 1);
    push1(8'hA5);
    tick(8);
    chk("post_clr_cnt1", word_cnt1, 1);
    chk("post_clr_drained1", exp_q1.size(), 0);
    chk("post_clr_valid1", m_valid1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
